load_store_unit: RTL and testbench

- Sits directly upstream of the word-only data RAM (32-bit words, word index from Addr[9:2], level-sensitive R/W strobes) and is driven by the CPU memory stage.
- Executes MIPS loads and stores: LB, LBU, LH, LHU, LW, SB, SH and SW.
- Sub-word stores run as a sequenced read-modify-write, because the RAM has no byte enables.
- Extracts and extends load data, flags misaligned or illegal requests, and exposes a busy/done handshake to the CPU.

---
 rtl/load_store_unit_pkg.sv | 32 +++
 rtl/byte_lane_fmt.sv | 42 ++++
 rtl/load_store_unit.sv | 124 ++++++++++++
 tb/tb_load_store_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: MIPS size codes, FSM encoding and
// the request legality check.
package load_store_unit_pkg;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b011;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD     = 3'd1,
      ST_RMW_RD = 3'd2,
      ST_WR     = 3'd3,
      ST_DONE   = 3'd4
   } lsu_state_e;

   // Unsigned sizes only make sense for loads; halves and words must be naturally aligned.
   function automatic logic req_illegal(input logic is_store, input logic [2:0] size,
                                        input logic [1:0] lane);
      case (size)
         SZ_B:    req_illegal = 1'b0;
         SZ_H:    req_illegal = lane[0];
         SZ_W:    req_illegal = (lane != 2'b00);
         SZ_BU:   req_illegal = is_store;
         SZ_HU:   req_illegal = is_store | lane[0];
         default: req_illegal = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/byte_lane_fmt.sv
// Combinational byte/half lane steering: extracts and extends load data, and merges
// store data into an old word for the read-modify-write path.
module byte_lane_fmt
   import load_store_unit_pkg::*;
#(
   parameter logic BigEndian = 1'b1
) (
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  lane,
   input  logic [2:0]  size,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic        is_byte;
   logic [4:0]  shamt;
   logic [31:0] shifted;
   logic [31:0] lane_mask;
   logic [31:0] wfield;

   always_comb begin
      is_byte = (size[1:0] == 2'b00);
      // Bit offset of the addressed lane; big-endian puts offset 0 in the top byte.
      if (is_byte) shamt = BigEndian ? {~lane, 3'b000} : {lane, 3'b000};
      else         shamt = BigEndian ? {~lane[1], 4'b0000} : {lane[1], 4'b0000};

      shifted = word >> shamt;
      case (size)
         SZ_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
         SZ_BU:   load_data = {24'h0, shifted[7:0]};
         SZ_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
         SZ_HU:   load_data = {16'h0, shifted[15:0]};
         default: load_data = word;
      endcase

      lane_mask = (is_byte ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
      wfield    = (wdata & (is_byte ? 32'h0000_00FF : 32'h0000_FFFF)) << shamt;
      merged    = (word & ~lane_mask) | wfield;
   end

endmodule

// File: rtl/load_store_unit.sv
// MIPS load/store unit in front of a word-only RAM; sub-word stores are sequenced
// as read-modify-write because the RAM has no byte enables.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int   AddrWidth = 32,
   parameter logic BigEndian = 1'b1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 req,
   input  logic                 is_store,
   input  logic [2:0]           size,
   input  logic [AddrWidth-1:0] addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [AddrWidth-1:0] ram_addr,
   output logic                 ram_r,
   output logic                 ram_w,
   output logic [31:0]          ram_wdata,
   input  logic [31:0]          ram_rdata,
   output logic [2:0]           state_dbg
);

   // Handshake: req is sampled only in IDLE; busy covers every non-IDLE state, and
   // done (with err for rejected requests) pulses for exactly one cycle at the end.

   lsu_state_e  state, state_nxt;
   logic [2:0]  st_size;
   logic [1:0]  st_lane;
   logic [31:0] st_wdata;
   logic        st_err;
   logic        illegal;
   logic [31:0] fmt_load;
   logic [31:0] fmt_merged;

   assign illegal   = req_illegal(is_store, size, addr[1:0]);
   assign state_dbg = state;

   byte_lane_fmt #(.BigEndian(BigEndian)) u_fmt (
      .word      (ram_rdata),
      .wdata     (st_wdata),
      .lane      (st_lane),
      .size      (st_size),
      .load_data (fmt_load),
      .merged    (fmt_merged)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Strobes decode from the registered state only, so they cannot glitch.
   always_comb begin
      state_nxt = state;
      ram_r     = 1'b0;
      ram_w     = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (req) begin
               if (illegal)          state_nxt = ST_DONE;
               else if (!is_store)   state_nxt = ST_RD;
               else if (size == SZ_W) state_nxt = ST_WR;
               else                  state_nxt = ST_RMW_RD;
            end
         end
         ST_RD: begin
            ram_r     = 1'b1;
            state_nxt = ST_DONE;
         end
         ST_RMW_RD: begin
            ram_r     = 1'b1;
            state_nxt = ST_WR;
         end
         ST_WR: begin
            ram_w     = 1'b1;
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            err       = st_err;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         st_size   <= '0;
         st_lane   <= '0;
         st_wdata  <= '0;
         st_err    <= 1'b0;
         rdata     <= '0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  st_size  <= size;
                  st_lane  <= addr[1:0];
                  st_wdata <= wdata;
                  st_err   <= illegal;
                  ram_addr <= {addr[AddrWidth-1:2], 2'b00};
                  if (!illegal && is_store && size == SZ_W) ram_wdata <= wdata;
               end
            end
            ST_RD:     rdata     <= fmt_load;
            ST_RMW_RD: ram_wdata <= fmt_merged;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: big-endian instance driven from a vector table with a
// done-driven scoreboard, plus a little-endian instance for lane-order checks.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   // ---------------- clock / reset ----------------
   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   logic        req = 1'b0, req_le = 1'b0;
   logic        is_store = 1'b0;
   logic [2:0]  size = 3'b000;
   logic [31:0] addr = '0, wdata = '0;

   logic [31:0] rdata, ram_addr, ram_wdata, ram_rdata;
   logic        busy, done, err, ram_r, ram_w;
   logic [2:0]  state_dbg;
   logic [31:0] rdata_le, ram_addr_le, ram_wdata_le, ram_rdata_le;
   logic        busy_le, done_le, err_le, ram_r_le, ram_w_le;
   logic [2:0]  state_dbg_le;

   load_store_unit #(.AddrWidth(32), .BigEndian(1'b1)) dut (
      .CLK(CLK), .RST(RST), .req(req), .is_store(is_store), .size(size), .addr(addr),
      .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
      .ram_addr(ram_addr), .ram_r(ram_r), .ram_w(ram_w), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .state_dbg(state_dbg)
   );

   load_store_unit #(.AddrWidth(32), .BigEndian(1'b0)) dut_le (
      .CLK(CLK), .RST(RST), .req(req_le), .is_store(is_store), .size(size), .addr(addr),
      .wdata(wdata), .rdata(rdata_le), .busy(busy_le), .done(done_le), .err(err_le),
      .ram_addr(ram_addr_le), .ram_r(ram_r_le), .ram_w(ram_w_le), .ram_wdata(ram_wdata_le),
      .ram_rdata(ram_rdata_le), .state_dbg(state_dbg_le)
   );

   // ---------------- RAM models ----------------
   logic [31:0] mem    [0:255];
   logic [31:0] mem_le [0:255];
   logic        mem_ld = 1'b0;
   logic [7:0]  ld_idx = '0;
   logic [31:0] ld_val = '0;

   assign ram_rdata    = mem[ram_addr[9:2]];
   assign ram_rdata_le = mem_le[ram_addr_le[9:2]];

   always @(posedge CLK) begin
      if (mem_ld) begin
         mem[ld_idx]    <= ld_val;
         mem_le[ld_idx] <= ld_val;
      end else begin
         if (ram_w)    mem[ram_addr[9:2]]       <= ram_wdata;
         if (ram_w_le) mem_le[ram_addr_le[9:2]] <= ram_wdata_le;
      end
   end

   logic watch_w = 1'b0;
   logic w_seen  = 1'b0;
   always @(posedge ram_w) if (watch_w) w_seen = 1'b1;

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [32:0] exp_q[$];
   logic [31:0] model_rdata = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge CLK) begin : sb_monitor
      logic [32:0] e;
      if (!RST && done) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected_done: got done=1 expected no completion");
         end else begin
            e = exp_q.pop_front();
            check("sb_err", {31'b0, err}, {31'b0, e[32]});
            check("sb_rdata", rdata, e[31:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   typedef struct {
      logic        st;
      logic [2:0]  sz;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic [7:0]  rm;
      logic [7:0]  wm;
      logic [31:0] wv;
   } vec_t;

   vec_t vecs [17];

   task automatic preload(input logic [7:0] idx, input logic [31:0] val);
      @(negedge CLK);
      mem_ld = 1'b1; ld_idx = idx; ld_val = val;
      @(posedge CLK);
      #1 mem_ld = 1'b0;
   endtask

   task automatic run_op(input vec_t v, input string tag);
      int          cyc;
      logic [7:0]  rm, wm;
      logic [31:0] wv;
      bit          seen;
      @(negedge CLK);
      req = 1'b1; is_store = v.st; size = v.sz; addr = v.a; wdata = v.wd;
      if (!v.st && !v.er) model_rdata = v.rd;
      exp_q.push_back({v.er, model_rdata});
      @(posedge CLK);
      #1 req = 1'b0;
      cyc = 0; rm = '0; wm = '0; wv = '0; seen = 0;
      while (!seen && cyc < 7) begin
         @(negedge CLK);
         cyc++;
         rm[cyc] = ram_r;
         wm[cyc] = ram_w;
         if (ram_w) wv = ram_wdata;
         if (cyc == 1 && !v.er) check({tag, "_ram_addr"}, ram_addr, {v.a[31:2], 2'b00});
         if (done) seen = 1;
      end
      check({tag, "_latency"}, seen ? 32'(cyc) : 32'd99, 32'(v.lat));
      check({tag, "_ram_r_cycles"}, {24'b0, rm}, {24'b0, v.rm});
      check({tag, "_ram_w_cycles"}, {24'b0, wm}, {24'b0, v.wm});
      if (v.wm != 8'h00) check({tag, "_ram_wdata"}, wv, v.wv);
   endtask

   task automatic run_le(input logic st, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input int lat, input logic [31:0] rd,
                         input string tag);
      int cyc;
      @(negedge CLK);
      req_le = 1'b1; is_store = st; size = sz; addr = a; wdata = wd;
      @(posedge CLK);
      #1 req_le = 1'b0;
      cyc = 0;
      while (!done_le && cyc < 8) begin
         @(negedge CLK);
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'(lat));
      if (!st) check({tag, "_rdata"}, rdata_le, rd);
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      int cyc;
      int n_done;
      int n_extra;

      //            st    sz      addr    wdata          rdata          er    lat rm     wm     ram_wdata
      vecs[0]  = '{1'b0, 3'b000, 32'h11, 32'h0,         32'hFFFFFF99, 1'b0, 2, 8'h02, 8'h00, 32'h0};
      vecs[1]  = '{1'b0, 3'b100, 32'h13, 32'h0,         32'h000000BB, 1'b0, 2, 8'h02, 8'h00, 32'h0};
      vecs[2]  = '{1'b0, 3'b001, 32'h10, 32'h0,         32'hFFFF8899, 1'b0, 2, 8'h02, 8'h00, 32'h0};
      vecs[3]  = '{1'b0, 3'b101, 32'h12, 32'h0,         32'h0000AABB, 1'b0, 2, 8'h02, 8'h00, 32'h0};
      vecs[4]  = '{1'b0, 3'b011, 32'h10, 32'h0,         32'h8899AABB, 1'b0, 2, 8'h02, 8'h00, 32'h0};
      vecs[5]  = '{1'b1, 3'b000, 32'h13, 32'h123456CC,  32'h0,        1'b0, 3, 8'h02, 8'h04, 32'h8899AACC};
      vecs[6]  = '{1'b0, 3'b011, 32'h10, 32'h0,         32'h8899AACC, 1'b0, 2, 8'h02, 8'h00, 32'h0};
      vecs[7]  = '{1'b1, 3'b001, 32'h10, 32'h0000BEEF,  32'h0,        1'b0, 3, 8'h02, 8'h04, 32'hBEEFAACC};
      vecs[8]  = '{1'b0, 3'b011, 32'h10, 32'h0,         32'hBEEFAACC, 1'b0, 2, 8'h02, 8'h00, 32'h0};
      vecs[9]  = '{1'b1, 3'b011, 32'h14, 32'hDEADBEEF,  32'h0,        1'b0, 2, 8'h00, 8'h02, 32'hDEADBEEF};
      vecs[10] = '{1'b0, 3'b011, 32'h14, 32'h0,         32'hDEADBEEF, 1'b0, 2, 8'h02, 8'h00, 32'h0};
      vecs[11] = '{1'b1, 3'b001, 32'h11, 32'h0000F00D,  32'h0,        1'b1, 1, 8'h00, 8'h00, 32'h0};
      vecs[12] = '{1'b0, 3'b011, 32'h12, 32'h0,         32'h0,        1'b1, 1, 8'h00, 8'h00, 32'h0};
      vecs[13] = '{1'b1, 3'b100, 32'h10, 32'h000000EE,  32'h0,        1'b1, 1, 8'h00, 8'h00, 32'h0};
      vecs[14] = '{1'b0, 3'b010, 32'h10, 32'h0,         32'h0,        1'b1, 1, 8'h00, 8'h00, 32'h0};
      vecs[15] = '{1'b0, 3'b011, 32'h10, 32'h0,         32'hBEEFAACC, 1'b0, 2, 8'h02, 8'h00, 32'h0};
      vecs[16] = '{1'b0, 3'b000, 32'h12, 32'h0,         32'hFFFFFFAA, 1'b0, 2, 8'h02, 8'h00, 32'h0};

      // Reset values while RST is held.
      repeat (2) @(posedge CLK);
      #1;
      check("reset_rdata", rdata, 32'h0);
      check("reset_ram_addr", ram_addr, 32'h0);
      check("reset_ram_wdata", ram_wdata, 32'h0);
      check("reset_flags", {27'b0, busy, done, err, ram_r, ram_w}, 32'h0);
      check("reset_state", {29'b0, state_dbg}, 32'(ST_IDLE));

      preload(8'd4, 32'h8899AABB);
      preload(8'd5, 32'h11223344);
      @(negedge CLK);
      RST = 1'b0;

      for (int i = 0; i < 17; i++) run_op(vecs[i], $sformatf("vec%0d", i));

      // Reset during RMW_RD: everything drops at once and no write follows.
      @(negedge CLK);
      req = 1'b1; is_store = 1'b1; size = 3'b000; addr = 32'h10; wdata = 32'h000000A5;
      @(posedge CLK);
      #1 req = 1'b0;
      @(negedge CLK);
      check("rmw_state_before_reset", {29'b0, state_dbg}, 32'(ST_RMW_RD));
      watch_w = 1'b1;
      RST = 1'b1;
      #1;
      check("rst_mid_flags", {27'b0, busy, done, err, ram_r, ram_w}, 32'h0);
      check("rst_mid_rdata", rdata, 32'h0);
      check("rst_mid_ram_addr", ram_addr, 32'h0);
      check("rst_mid_ram_wdata", ram_wdata, 32'h0);
      model_rdata = 32'h0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      watch_w = 1'b0;
      check("rst_mid_no_write", {31'b0, w_seen}, 32'h0);
      check("rst_mid_word_kept", mem[4], 32'hBEEFAACC);
      check("rst_mid_busy_after", {31'b0, busy}, 32'h0);

      // req held high through an SB, including the DONE-ending edge: one completion only.
      @(negedge CLK);
      req = 1'b1; is_store = 1'b1; size = 3'b000; addr = 32'h10; wdata = 32'h00000055;
      exp_q.push_back({1'b0, model_rdata});
      @(posedge CLK);
      cyc = 0; n_done = 0;
      while (n_done == 0 && cyc < 10) begin
         @(negedge CLK);
         cyc++;
         if (cyc == 2) check("busy_hold_mid", {31'b0, busy}, 32'h1);
         if (done) n_done++;
      end
      check("busy_hold_latency", 32'(cyc), 32'd3);
      @(posedge CLK);
      #1 req = 1'b0;
      n_extra = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         if (done) n_extra++;
      end
      check("busy_hold_extra_done", 32'(n_extra), 32'h0);
      check("busy_hold_idle", {31'b0, busy}, 32'h0);
      check("busy_hold_word", mem[4], 32'h55EFAACC);

      // Back-to-back loads re-issued in IDLE.
      run_op('{1'b0, 3'b011, 32'h10, 32'h0, 32'h55EFAACC, 1'b0, 2, 8'h02, 8'h00, 32'h0}, "b2b_lw");
      run_op('{1'b0, 3'b000, 32'h10, 32'h0, 32'h00000055, 1'b0, 2, 8'h02, 8'h00, 32'h0}, "b2b_lb");
      run_op('{1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFAACC, 1'b0, 2, 8'h02, 8'h00, 32'h0}, "b2b_lh");

      // Little-endian instance: its RAM still holds the preload value in word 4.
      run_le(1'b1, 3'b000, 32'h10, 32'h000000CC, 3, 32'h0, "le_sb");
      @(negedge CLK);
      check("le_sb_word", mem_le[4], 32'h8899AACC);
      run_le(1'b0, 3'b001, 32'h12, 32'h0, 2, 32'hFFFF8899, "le_lh");
      run_le(1'b0, 3'b000, 32'h11, 32'h0, 2, 32'hFFFFFFAA, "le_lb");

      repeat (3) @(negedge CLK);
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got no end of test expected finish before 100000ns");
      $fatal(1, "watchdog expired");
   end

endmodule
